// File: rtl/uart_pkg.sv
// Shared definitions for the UART TX frame serialiser and the matching RX checkers.
//   tx_state_e  : transmit FSM states
//   PAR_EVEN    : par_typ value selecting even parity
//   PAR_ODD     : par_typ value selecting odd parity
//   IDLE_LEVEL  : level of the serial line when idle and during the stop bit
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam logic PAR_EVEN   = 1'b0;
    localparam logic PAR_ODD    = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_frame_if.sv
// Request/line bundle between a UART TX client and uart_tx_frame.
//   p_data     : word to send
//   data_valid : send request
//   par_en     : insert parity bit
//   par_typ    : 0 even, 1 odd
//   prescale   : clk cycles per bit (0 behaves as 1)
//   tx_out     : serial line, idle high
//   busy       : frame in progress
// master = client issuing requests, slave = transmitter.
interface uart_tx_frame_if #(
    parameter int DW    = 8,
    parameter int PSC_W = 6
);
    logic [DW-1:0]    p_data;
    logic             data_valid;
    logic             par_en;
    logic             par_typ;
    logic [PSC_W-1:0] prescale;
    logic             tx_out;
    logic             busy;

    modport master (
        output p_data, data_valid, par_en, par_typ, prescale,
        input  tx_out, busy
    );

    modport slave (
        input  p_data, data_valid, par_en, par_typ, prescale,
        output tx_out, busy
    );
endinterface

// File: rtl/uart_tx_parity.sv
// Combinational parity of a DW-bit word.
//   data_i    : word
//   par_typ_i : 0 even, 1 odd
//   par_o     : parity bit to transmit
module uart_tx_parity
    import uart_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [DW-1:0] data_i,
    input  logic          par_typ_i,
    output logic          par_o
);
    // Odd parity is the inverse of even parity on the same word.
    assign par_o = (^data_i) ^ (par_typ_i == PAR_ODD);
endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: one word per accepted request, sent as start bit, DW data
// bits LSB first, optional parity bit and one stop bit, each held for P clk
// cycles where P is the prescale latched on accept (0 treated as 1).
//   clk : system clock
//   rst : asynchronous active-high reset
//   bus : uart_tx_frame_if slave (request inputs, tx_out/busy outputs)
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DW    = 8,
    parameter int PSC_W = 6
) (
    input  logic           clk,
    input  logic           rst,
    uart_tx_frame_if.slave bus
);
    localparam int               IDX_W    = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DW - 1);
    localparam logic [PSC_W-1:0] PSC_ONE  = PSC_W'(1);

    tx_state_e        state_q, state_d;
    logic [PSC_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;

    logic [DW-1:0]    data_q;
    logic             par_en_q;
    logic             par_typ_q;
    logic [PSC_W-1:0] psc_q;

    logic             accept;
    logic             bit_end;
    logic             par_bit;

    assign accept = (state_q == IDLE) && bus.data_valid;

    // Frame parameters only change on accept, so nothing needs a reset value.
    always_ff @(posedge clk) begin
        if (accept) begin
            data_q    <= bus.p_data;
            par_en_q  <= bus.par_en;
            par_typ_q <= bus.par_typ;
            psc_q     <= (bus.prescale == '0) ? PSC_ONE : bus.prescale;
        end
    end

    uart_tx_parity #(
        .DW(DW)
    ) u_parity (
        .data_i   (data_q),
        .par_typ_i(par_typ_q),
        .par_o    (par_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            tx_q    <= IDLE_LEVEL;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        bit_end = (cnt_q == (psc_q - PSC_ONE));
        tx_d    = IDLE_LEVEL;
        busy_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.data_valid) begin
                    state_d = START;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + PSC_ONE;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = par_en_q ? PARITY : STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + PSC_ONE;
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + PSC_ONE;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + PSC_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase

        // Outputs are decoded from the next state so the registered line and
        // busy flag line up exactly with the state they belong to.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = data_q[idx_d];
            PARITY:  tx_d = par_bit;
            default: tx_d = IDLE_LEVEL;
        endcase
        busy_d = (state_d != IDLE);
    end

    assign bus.tx_out = tx_q;
    assign bus.busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
module tb_uart_tx_frame;
    import uart_pkg::*;

    logic clk;
    logic rst;

    uart_tx_frame_if #(.DW(8), .PSC_W(6)) bus ();

    uart_tx_frame #(.DW(8), .PSC_W(6)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic exp_q[$];   // expected tx_out for every busy cycle
    int   len_q[$];   // expected busy run length per frame

    // Reference frame: list of bits from the frame rules, each stretched to P clks.
    function automatic void push_frame(input logic [7:0] d, input logic pe,
                                       input logic pt, input logic [5:0] psc);
        int   p;
        logic bits[$];
        p = (psc == 6'd0) ? 1 : int'(psc);
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (pe) bits.push_back((($countones(d) % 2) == 1) ? ~pt : pt);
        bits.push_back(IDLE_LEVEL);
        foreach (bits[k]) repeat (p) exp_q.push_back(bits[k]);
        len_q.push_back(p * bits.size());
    endfunction

    task automatic check(input string nm, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s got %0d expected %0d at %0t", nm, act, req, $time);
        end
    endtask

    task automatic wait_busy(input logic lvl, input int maxc, input string nm);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.busy !== lvl && n < maxc);
        if (bus.busy !== lvl) begin
            tests++;
            fails++;
            $display("FAIL %s timeout busy=%b wanted %b at %0t", nm, bus.busy, lvl, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every busy cycle.
    logic mon_prev_busy = 1'b0;
    int   mon_run = 0;
    always @(negedge clk) begin
        if (rst) begin
            check("rst_tx", int'(bus.tx_out), 1);
            check("rst_busy", int'(bus.busy), 0);
            mon_run = 0;
            mon_prev_busy = 1'b0;
        end else begin
            if (bus.busy) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL extra_bit got tx=%b expected no frame at %0t", bus.tx_out, $time);
                end else begin
                    check("tx_bit", int'(bus.tx_out), int'(exp_q.pop_front()));
                end
                mon_run++;
            end else begin
                check("idle_line", int'(bus.tx_out), 1);
                if (mon_prev_busy) begin
                    if (len_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL busy_len got %0d expected no frame", mon_run);
                    end else begin
                        check("busy_len", mon_run, len_q.pop_front());
                    end
                    mon_run = 0;
                end
            end
            mon_prev_busy = bus.busy;
        end
    end

    task automatic send(input logic [7:0] d, input logic pe, input logic pt,
                        input logic [5:0] psc, input bit pulse);
        @(posedge clk); #1;
        bus.p_data     = d;
        bus.par_en     = pe;
        bus.par_typ    = pt;
        bus.prescale   = psc;
        bus.data_valid = 1'b1;
        push_frame(d, pe, pt, psc);
        wait_busy(1'b1, 4, "accept");
        @(posedge clk); #1;
        bus.data_valid = 1'b0;
        bus.p_data     = 8'($urandom);
        bus.par_en     = 1'($urandom);
        bus.par_typ    = 1'($urandom);
        bus.prescale   = 6'($urandom);
        if (pulse) begin
            repeat (2) @(posedge clk);
            #1;
            bus.data_valid = 1'b1;
            bus.p_data     = 8'($urandom);
            @(posedge clk); #1;
            bus.data_valid = 1'b0;
        end
        wait_busy(1'b0, 800, "frame_end");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int gap;
        rst            = 1'b1;
        bus.p_data     = '0;
        bus.data_valid = 1'b0;
        bus.par_en     = 1'b0;
        bus.par_typ    = PAR_EVEN;
        bus.prescale   = '0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;

        // Directed frames
        send(8'hA5, 1'b1, PAR_EVEN, 6'd4, 1'b0);
        send(8'hA5, 1'b1, PAR_ODD,  6'd4, 1'b0);
        send(8'h00, 1'b0, PAR_EVEN, 6'd1, 1'b0);
        send(8'hFF, 1'b1, PAR_EVEN, 6'd0, 1'b0);

        // Back-to-back with data_valid held, then an ignored mid-frame pulse
        @(posedge clk); #1;
        bus.p_data = 8'h3C; bus.par_en = 1'b1; bus.par_typ = PAR_ODD;
        bus.prescale = 6'd2; bus.data_valid = 1'b1;
        push_frame(8'h3C, 1'b1, PAR_ODD, 6'd2);
        wait_busy(1'b1, 4, "b2b_accept1");
        @(posedge clk); #1;
        bus.p_data = 8'hC3;
        push_frame(8'hC3, 1'b1, PAR_ODD, 6'd2);
        wait_busy(1'b0, 100, "b2b_end1");
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (!bus.busy && gap < 10);
        check("b2b_gap", gap, 1);
        @(posedge clk); #1;
        bus.data_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        bus.data_valid = 1'b1;
        bus.p_data = 8'h77;
        @(posedge clk); #1;
        bus.data_valid = 1'b0;
        wait_busy(1'b0, 100, "b2b_end2");

        // Reset during data bit 3
        @(posedge clk); #1;
        bus.p_data = 8'h96; bus.par_en = 1'b1; bus.par_typ = PAR_EVEN;
        bus.prescale = 6'd4; bus.data_valid = 1'b1;
        push_frame(8'h96, 1'b1, PAR_EVEN, 6'd4);
        wait_busy(1'b1, 4, "rst_accept");
        @(posedge clk); #1;
        bus.data_valid = 1'b0;
        repeat (16) @(negedge clk);
        #2;
        rst = 1'b1;
        exp_q.delete();
        len_q.delete();
        #1;
        check("rst_async_tx", int'(bus.tx_out), 1);
        check("rst_async_busy", int'(bus.busy), 0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        send(8'h5A, 1'b1, PAR_ODD, 6'd3, 1'b0);

        // Randomized frames
        for (int n = 0; n < 24; n++) begin
            send(8'($urandom), 1'($urandom), 1'($urandom),
                 6'($urandom_range(0, 6)), bit'($urandom_range(0, 1)));
        end

        repeat (4) @(negedge clk);
        check("exp_q_empty", exp_q.size(), 0);
        check("len_q_empty", len_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
